if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives the instruction SRAM port and feeds ID.
//  Produces if_to_id_bus {ce, pc} and consumes br_bus {br_e, br_addr} returned from ID.
//  Holds the SRAM read data in a one-entry replay buffer while ID is stalled,
//  so ID never needs to retain instruction state across a stall.
//  Latches branch redirects that arrive while the PC is frozen.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000   address of the first fetch after reset
// PORTS
//  clk              in   1             clock
//  rst              in   1             asynchronous, active-high reset
//  flush            in   1             pipeline flush; redirect fetch to flush_pc
//  flush_pc         in   32            flush target
//  stall            in   `StallBus     stall[0]=PC hold, stall[1]=IF/ID hold (`Stop=1)
//  br_bus           in   `BR_WD        {br_e, br_addr[31:0]} from ID
//  inst_sram_rdata  in   32            SRAM read data, valid 1 cycle after the address
//  inst_sram_en     out  1             SRAM enable
//  inst_sram_wen    out  4             tied 4'b0
//  inst_sram_addr   out  32            fetch address
//  inst_sram_wdata  out  32            tied 32'b0
//  if_to_id_bus     out  `IF_TO_ID_WD  {ce, pc}; this is the address whose data is on rdata this cycle
//  if_inst          out  32            instruction for ID: buffered word if buf_valid, else inst_sram_rdata
//  if_excp_adel     out  1             fetch-address error flag for ID (see CONFIGURATION)
// BEHAVIOUR
//  - Registers: pc_r, ce_r, buf_r, buf_valid, br_pend, br_tgt_r.
//  - Reset (asynchronous):
//    - pc_r=RESET_PC-4 and ce_r=0. Every other register and if_excp_adel reset to 0.
//    - Outputs during reset: inst_sram_en=0 and if_to_id_bus=0.
//  - next_pc, first matching rule wins:
//    1. flush -> flush_pc
//    2. stall[0]==`Stop -> pc_r (hold)
//    3. br_e -> br_addr
//    4. br_pend -> br_tgt_r
//    5. otherwise pc_r+4
//  - Register update: pc_r<=next_pc each cycle unless held. ce_r<=1 on the first
//    non-held cycle after reset.
//  - SRAM drive: inst_sram_addr=next_pc; inst_sram_en=ce_next & ~stall[0].
//    One-cycle read latency, so rdata pairs with pc_r.
//  - Branch pending:
//    - br_e while stall[0]==`Stop: br_pend<=1, br_tgt_r<=br_addr.
//    - br_pend clears on the first non-held cycle or on flush.
//    - A live br_e in the release cycle overrides br_tgt_r.
//  - Replay buffer:
//    - Capture: stall[1]==`Stop && !buf_valid -> buf_r<=inst_sram_rdata, buf_valid<=1.
//    - Clear: buf_valid<=0 when stall[1]==`NoStop, or on flush.
//    - Re-stall in the release cycle: captures fresh data.
//  - Flush mid-stall: flush wins. Buffer and pending branch are dropped;
//    fetch restarts at flush_pc the next cycle.
//  - Arithmetic: pc+4 wraps modulo 2^32 with no trap.
//  - State view: RUN (buf_valid=0), HOLD (buf_valid=1), PEND (br_pend=1);
//    HOLD and PEND can coexist.
// CONFIGURATION
//  - IF_ADDR_EXC_EN defined:
//    - if_excp_adel=|pc_r[1:0] & ce_r, registered alongside pc_r.
//    - inst_sram_en is forced to 0 for a misaligned next_pc.
//    - if_inst reads 32'b0 while the flag is set.
//  - IF_ADDR_EXC_EN undefined: if_excp_adel tied 0; misaligned addresses are fetched as-is.
// STRUCTURE
//  - lib/defines.vh holds `StallBus, `IF_TO_ID_WD (33), `BR_WD (33), `Stop/`NoStop.
//    RESET_PC is a localparam default only.
//  - Sub-module if_inst_buf: one-entry replay buffer (capture/clear/flush, mux to if_inst).
//  - PC and branch-pending logic stay inline.
// TESTING
//  1. Reset release with no stall: successive inst_sram_addr = BFC00000, BFC00004,
//     BFC00008. ce=0 in the first cycle after reset, then 1.
//  2. stall[1:0]=2'b11 for 3 cycles, rdata changing each cycle:
//     if_inst holds the first captured word; pc_r is frozen; it advances on release.
//  3. br_e=1, br_addr=BFC00100 while stall[0]=1, held 2 cycles then released:
//     next address = BFC00100 and br_pend clears.
//  4. flush=1, flush_pc=BFC00380 during HOLD with br_pend=1:
//     next address = BFC00380, buf_valid=0, br_pend=0.
//  5. rst asserted asynchronously mid-stream: outputs drop to 0 immediately;
//     the first fetch after release = RESET_PC.
//  6. With IF_ADDR_EXC_EN, br_addr=BFC00102: if_excp_adel=1, inst_sram_en=0, if_inst=0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_pkg
// Description : Shared widths, stall encodings and bus structs for the
//               instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

  // Stall bus: bit 0 freezes the PC, bit 1 freezes the IF/ID boundary
  localparam int STALL_W     = 2;
  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD       = 33;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Branch redirect returned from ID
  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  // Fetch descriptor handed to ID
  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  // True when an address is not word aligned
  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_inst_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_inst_buf
// Description : One-entry replay buffer between the instruction SRAM and ID.
//               Captures the SRAM word on the first stalled cycle and replays
//               it until the stall releases, so ID keeps no instruction state.
// Revision    : 1.0 - initial release
// ============================================================================
module if_inst_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,       // IF/ID boundary is stalled
  input  logic        kill,       // force a zero instruction (address error)
  input  logic [31:0] rdata,
  output logic [31:0] inst
);

  logic [31:0] buf_d;
  logic [31:0] buf_q;
  logic        buf_valid_d;
  logic        buf_valid_q;

  // Capture on the first held cycle; drop on release or flush
  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    if (flush || !hold) begin
      buf_valid_d = 1'b0;
    end else if (!buf_valid_q) begin
      buf_d       = rdata;
      buf_valid_d = 1'b1;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q       <= 32'b0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Replayed word takes precedence over the live SRAM output
  always_comb begin
    inst = buf_valid_q ? buf_q : rdata;
    if (kill) begin
      inst = 32'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage. Owns the PC, drives the instruction
//               SRAM, latches branch redirects that arrive while the PC is
//               frozen and replays the fetched word across ID stalls.
//               Optional feature macro: IF_ADDR_EXC_EN (misaligned-fetch flag).
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  input  logic [31:0]            inst_sram_rdata,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            if_inst,
  output logic                   if_excp_adel
);

  br_bus_t     br;
  if_to_id_t   id_view;

  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic        ce_d;
  logic        ce_q;
  logic        br_pend_d;
  logic        br_pend_q;
  logic [31:0] br_tgt_d;
  logic [31:0] br_tgt_q;
  logic        excp_d;
  logic        excp_q;
  logic        pc_stop;
  logic        pc_hold;
  logic        addr_ok;

  assign br      = br_bus_t'(br_bus);
  assign pc_stop = (stall[0] == STOP);
  // A flush moves the PC even when stall[0] is asserted
  assign pc_hold = pc_stop && !flush;

  // Next-PC priority: flush, hold, live branch, pending branch, sequential
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (flush) begin
      pc_d = flush_pc;
    end else if (pc_stop) begin
      pc_d = pc_q;
    end else if (br.br_e) begin
      pc_d = br.br_addr;
    end else if (br_pend_q) begin
      pc_d = br_tgt_q;
    end
    ce_d = pc_hold ? ce_q : 1'b1;
  end

  // Remember a redirect that lands while the PC is frozen
  always_comb begin
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    if (flush) begin
      br_pend_d = 1'b0;
    end else if (pc_stop) begin
      if (br.br_e) begin
        br_pend_d = 1'b1;
        br_tgt_d  = br.br_addr;
      end
    end else begin
      br_pend_d = 1'b0;
    end
  end

`ifdef IF_ADDR_EXC_EN
  // Misalignment flag follows the PC register, so it tracks the word on rdata
  always_comb begin
    excp_d  = pc_hold ? excp_q : (is_misaligned(pc_d) & ce_d);
    addr_ok = !is_misaligned(pc_d);
  end
`else
  // Misaligned addresses are fetched as-is
  always_comb begin
    excp_d  = 1'b0;
    addr_ok = 1'b1;
  end
`endif

  // PC, fetch-enable and branch-pending registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC - 32'd4;
      ce_q      <= 1'b0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= 32'b0;
      excp_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ce_q      <= ce_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
      excp_q    <= excp_d;
    end
  end

  // SRAM port: address is the next PC so the data lines up with pc_q
  always_comb begin
    inst_sram_en    = !rst && ce_d && !pc_stop && addr_ok;
    inst_sram_addr  = pc_d;
    inst_sram_wen   = 4'b0;
    inst_sram_wdata = 32'b0;
  end

  // ID descriptor is zero until the first real fetch has been issued
  always_comb begin
    id_view.ce   = ce_q;
    id_view.pc   = ce_q ? pc_q : 32'b0;
    if_to_id_bus = id_view;
    if_excp_adel = excp_q;
  end

  if_inst_buf u_inst_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .hold  (stall[1] == STOP),
    .kill  (excp_q),
    .rdata (inst_sram_rdata),
    .inst  (if_inst)
  );

endmodule
`default_nettype wire
